// File: rtl/fracnet_t_div_s25_u9_if.sv
// Operand/result handshake bundle for the saturating signed-by-unsigned divider.
// The master side supplies operands and consumes results; the slave side is the divider.
interface fracnet_t_div_s25_u9_if #(
  parameter int DIVIDEND_WIDTH = 25,
  parameter int DIVISOR_WIDTH  = 9,
  parameter int QUOTIENT_WIDTH = 16
);
  logic                              in_valid;
  logic                              in_ready;
  logic signed [DIVIDEND_WIDTH-1:0]  dividend;
  logic        [DIVISOR_WIDTH-1:0]   divisor;
  logic                              out_valid;
  logic                              out_ready;
  logic signed [QUOTIENT_WIDTH-1:0]  quotient;
  logic signed [DIVISOR_WIDTH:0]     remainder;
  logic                              ovf;
  logic                              dz;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, ovf, dz
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, ovf, dz
  );
endinterface

// File: rtl/fracnet_t_div_s25_u9.sv
// Bit-serial restoring divider: signed dividend by unsigned divisor, one quotient bit per
// cycle, sign fix-up and saturation to the quotient width, divide-by-zero short cut.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | one restoring-division step per cycle on the dividend magnitude
// FIX   | apply dividend sign, saturate quotient, set ovf
// DONE  | result held until out_ready
module fracnet_t_div_s25_u9 #(
  parameter int DIVIDEND_WIDTH = 25,
  parameter int DIVISOR_WIDTH  = 9,
  parameter int QUOTIENT_WIDTH = 16
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  fracnet_t_div_s25_u9_if.slave   io
);
  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int QW = QUOTIENT_WIDTH;
  localparam int RW = DIVISOR_WIDTH + 1;
  localparam int CW = $clog2(DIVIDEND_WIDTH);

  localparam logic signed [DW:0]   Q_MAX_EXT = {{(DW + 2 - QW){1'b0}}, {(QW - 1){1'b1}}};
  localparam logic signed [DW:0]   Q_MIN_EXT = {{(DW + 2 - QW){1'b1}}, {(QW - 1){1'b0}}};
  localparam logic [QW-1:0]        Q_MAX     = {1'b0, {(QW - 1){1'b1}}};
  localparam logic [QW-1:0]        Q_MIN     = {1'b1, {(QW - 1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t         state_q, state_d;
  logic           neg_q, neg_d;
  logic [DW-1:0]  mag_q, mag_d;
  logic [VW-1:0]  rem_q, rem_d;
  logic [VW-1:0]  div_q, div_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [QW-1:0]  quo_q, quo_d;
  logic [RW-1:0]  rmd_q, rmd_d;
  logic           ovf_q, ovf_d;
  logic           dz_q, dz_d;

  logic [RW-1:0]        shift_rem;
  logic                 step_ge;
  logic [DW-1:0]        abs_in;
  logic signed [DW:0]   q_signed;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      mag_q   <= mag_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    neg_d   = neg_q;
    mag_d   = mag_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;

    // Magnitude of the most negative dividend still fits as an unsigned DW-bit value.
    abs_in    = io.dividend[DW-1] ? (~io.dividend + 1'b1) : io.dividend;
    shift_rem = {rem_q, mag_q[DW-1]};
    step_ge   = shift_rem >= {1'b0, div_q};
    q_signed  = neg_q ? -$signed({1'b0, mag_q}) : $signed({1'b0, mag_q});

    unique case (state_q)
      S_IDLE: begin
        if (io.in_valid) begin
          ovf_d = 1'b0;
          if (io.divisor == '0) begin
            dz_d    = 1'b1;
            rmd_d   = '0;
            quo_d   = io.dividend[DW-1] ? Q_MIN : Q_MAX;
            state_d = S_DONE;
          end else begin
            dz_d    = 1'b0;
            neg_d   = io.dividend[DW-1];
            mag_d   = abs_in;
            rem_d   = '0;
            div_d   = io.divisor;
            cnt_d   = CW'(DW - 1);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        // Quotient bits shift into the vacated low end of the magnitude register.
        rem_d = step_ge ? VW'(shift_rem - {1'b0, div_q}) : shift_rem[VW-1:0];
        mag_d = {mag_q[DW-2:0], step_ge};
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        rmd_d = neg_q ? -{1'b0, rem_q} : {1'b0, rem_q};
        if (q_signed > Q_MAX_EXT) begin
          quo_d = Q_MAX;
          ovf_d = 1'b1;
        end else if (q_signed < Q_MIN_EXT) begin
          quo_d = Q_MIN;
          ovf_d = 1'b1;
        end else begin
          quo_d = q_signed[QW-1:0];
          ovf_d = 1'b0;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (io.out_ready) begin
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign io.in_ready  = (state_q == S_IDLE);
  assign io.out_valid = (state_q == S_DONE);
  assign io.quotient  = quo_q;
  assign io.remainder = rmd_q;
  assign io.ovf       = ovf_q;
  assign io.dz        = dz_q;
endmodule

// File: tb/tb_fracnet_t_div_s25_u9.sv
// Self-checking bench for the saturating divider: directed corner cases, backpressure,
// mid-division reset and randomized operands against an integer-arithmetic reference.
module tb_fracnet_t_div_s25_u9;
  logic ap_clk = 1'b0;
  logic ap_rst;

  fracnet_t_div_s25_u9_if io ();
  fracnet_t_div_s25_u9 dut (.ap_clk(ap_clk), .ap_rst(ap_rst), .io(io));

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;

  // Reference: plain integer division (truncating, remainder takes dividend sign) then clamp.
  function automatic void model(input int dvd, input int dvs, output int q, output int r,
                                output bit ovf, output bit dz, output int lat);
    if (dvs == 0) begin
      dz = 1'b1; ovf = 1'b0; r = 0; lat = 1;
      q  = (dvd >= 0) ? 32767 : -32768;
    end else begin
      dz = 1'b0; ovf = 1'b0; lat = 27;
      q  = dvd / dvs;
      r  = dvd % dvs;
      if (q > 32767) begin q = 32767; ovf = 1'b1; end
      else if (q < -32768) begin q = -32768; ovf = 1'b1; end
    end
  endfunction

  task automatic start_op(input int dvd, input int dvs);
    io.dividend = 25'(dvd);
    io.divisor  = 9'(dvs);
    io.in_valid = 1'b1;
    checks++;
    if (io.in_ready !== 1'b1) begin
      errors++; $display("FAIL start_ready got %b want 1", io.in_ready);
    end
    @(posedge ap_clk); #1;
    io.in_valid = 1'b0;
    io.dividend = 25'($urandom);
    io.divisor  = 9'($urandom);
  endtask

  // lat=1 means out_valid was already up in the cycle right after the accept edge.
  task automatic wait_result(output int lat);
    lat = 1;
    while (io.out_valid !== 1'b1 && lat < 200) begin
      @(posedge ap_clk); #1;
      lat++;
    end
    if (io.out_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL result_timeout out_valid=%b after %0d cycles", io.out_valid, lat);
    end
  endtask

  task automatic consume();
    io.out_ready = 1'b1;
    @(posedge ap_clk); #1;
    io.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    io.in_valid = 1'b0; io.out_ready = 1'b0; io.dividend = '0; io.divisor = '0;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    checks += 6;
    if (io.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", io.in_ready); end
    if (io.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", io.out_valid); end
    if (io.quotient !== '0)    begin errors++; $display("FAIL reset_quotient got %0d want 0", io.quotient); end
    if (io.remainder !== '0)   begin errors++; $display("FAIL reset_remainder got %0d want 0", io.remainder); end
    if (io.ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf got %b want 0", io.ovf); end
    if (io.dz !== 1'b0)        begin errors++; $display("FAIL reset_dz got %b want 0", io.dz); end
  endtask

  task automatic test_directed();
    int dvd_t[6] = '{1000, -1000, 100000, -16777216, -5, 77};
    int dvs_t[6] = '{7, 7, 3, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      int eq, er, elat, lat, gq, gr;
      bit eovf, edz;
      model(dvd_t[i], dvs_t[i], eq, er, eovf, edz, elat);
      start_op(dvd_t[i], dvs_t[i]);
      wait_result(lat);
      gq = io.quotient; gr = io.remainder;
      checks += 5;
      if (gq !== eq) begin errors++; $display("FAIL dir_quotient %0d/%0d got %0d want %0d", dvd_t[i], dvs_t[i], gq, eq); end
      if (gr !== er) begin errors++; $display("FAIL dir_remainder %0d/%0d got %0d want %0d", dvd_t[i], dvs_t[i], gr, er); end
      if (io.ovf !== eovf) begin errors++; $display("FAIL dir_ovf %0d/%0d got %b want %b", dvd_t[i], dvs_t[i], io.ovf, eovf); end
      if (io.dz !== edz) begin errors++; $display("FAIL dir_dz %0d/%0d got %b want %b", dvd_t[i], dvs_t[i], io.dz, edz); end
      if (lat != elat) begin errors++; $display("FAIL dir_latency %0d/%0d got %0d want %0d", dvd_t[i], dvs_t[i], lat, elat); end
      consume();
      checks += 2;
      if (io.ovf !== 1'b0 || io.dz !== 1'b0) begin
        errors++; $display("FAIL dir_flags_idle got ovf=%b dz=%b want 0 0", io.ovf, io.dz);
      end
      if (io.out_valid !== 1'b0) begin errors++; $display("FAIL dir_out_valid_idle got %b want 0", io.out_valid); end
    end
  endtask

  task automatic test_backpressure();
    int lat, gq, gr;
    start_op(-1000, 7);
    wait_result(lat);
    for (int c = 0; c < 5; c++) begin
      io.in_valid = 1'b1;
      io.dividend = 25'($urandom);
      io.divisor  = 9'($urandom_range(1, 511));
      @(posedge ap_clk); #1;
      gq = io.quotient; gr = io.remainder;
      checks += 4;
      if (gq !== -142 || gr !== -6) begin errors++; $display("FAIL hold_result cyc %0d got %0d r %0d want -142 r -6", c, gq, gr); end
      if (io.out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid got %b want 1", io.out_valid); end
      if (io.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready got %b want 0", io.in_ready); end
      if (io.ovf !== 1'b0 || io.dz !== 1'b0) begin errors++; $display("FAIL hold_flags got %b %b want 0 0", io.ovf, io.dz); end
    end
    // Keep in_valid high through the release edge: the divider must not accept on it.
    io.dividend = 25'(50); io.divisor = 9'(5);
    io.out_ready = 1'b1;
    @(posedge ap_clk); #1;
    io.out_ready = 1'b0;
    checks += 2;
    if (io.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", io.in_ready); end
    if (io.out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid got %b want 0", io.out_valid); end
    @(posedge ap_clk); #1;
    io.in_valid = 1'b0;
    checks++;
    if (io.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept in_ready got %b want 0", io.in_ready); end
    wait_result(lat);
    gq = io.quotient; gr = io.remainder;
    checks += 2;
    if (gq !== 10 || gr !== 0) begin errors++; $display("FAIL b2b_result got %0d r %0d want 10 r 0", gq, gr); end
    if (lat != 27) begin errors++; $display("FAIL b2b_latency got %0d want 27", lat); end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat, gq, gr;
    bit seen;
    start_op(1000, 7);
    repeat (10) @(posedge ap_clk);
    #1 ap_rst = 1'b1;
    #1;
    checks += 3;
    if (io.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", io.out_valid); end
    if (io.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", io.in_ready); end
    if (io.quotient !== '0) begin errors++; $display("FAIL midrst_quotient got %0d want 0", io.quotient); end
    #2 ap_rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge ap_clk); #1;
      if (io.out_valid !== 1'b0 || io.ovf !== 1'b0 || io.dz !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midrst_stale_result got output activity want none"); end
    start_op(1000, 7);
    wait_result(lat);
    gq = io.quotient; gr = io.remainder;
    checks += 2;
    if (gq !== 142 || gr !== 6) begin errors++; $display("FAIL midrst_next got %0d r %0d want 142 r 6", gq, gr); end
    if (lat != 27) begin errors++; $display("FAIL midrst_latency got %0d want 27", lat); end
    consume();
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic signed [24:0] v;
      int dvd, dvs, eq, er, elat, lat, gq, gr;
      bit eovf, edz;
      v   = 25'($urandom);
      v   = v >>> $urandom_range(0, 24);
      dvd = v;
      dvs = $urandom_range(1, 511);
      model(dvd, dvs, eq, er, eovf, edz, elat);
      start_op(dvd, dvs);
      wait_result(lat);
      gq = io.quotient; gr = io.remainder;
      checks += 4;
      if (gq !== eq || gr !== er) begin
        errors++; $display("FAIL rnd_result %0d/%0d got %0d r %0d want %0d r %0d", dvd, dvs, gq, gr, eq, er);
      end
      if (io.ovf !== eovf || io.dz !== 1'b0) begin
        errors++; $display("FAIL rnd_flags %0d/%0d got ovf=%b dz=%b want ovf=%b dz=0", dvd, dvs, io.ovf, io.dz, eovf);
      end
      if (lat != elat) begin errors++; $display("FAIL rnd_latency %0d/%0d got %0d want %0d", dvd, dvs, lat, elat); end
      if (!eovf) begin
        if (gq * dvs + gr != dvd || gr >= dvs || -gr >= dvs || (gr != 0 && ((gr < 0) != (dvd < 0)))) begin
          errors++; $display("FAIL rnd_roundtrip %0d/%0d got q=%0d r=%0d want q*d+r=dividend", dvd, dvs, gq, gr);
        end
      end else if (!((dvd / dvs > 32767 && gq == 32767) || (dvd / dvs < -32768 && gq == -32768))) begin
        errors++; $display("FAIL rnd_saturation %0d/%0d got %0d want clamp of %0d", dvd, dvs, gq, dvd / dvs);
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random(1500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
